shot_clock_timer: RTL

- Parametrised shot-clock countdown for the scoreboard; next generation of the fixed 5-bit 24/14 countdown.
- Adds the following over the fixed version:
  - generic width and presets;
  - internal seconds prescaler;
  - start/stop toggle button with edge detection;
  - custom load;
  - explicit run/idle/expired FSM;
  - buzzer held for a programmable number of seconds.
- Sits between the board clock and the 7-segment decoder and buzzer driver.

---
 rtl/shot_clock_pkg.sv | 15 +
 rtl/shot_clock_timer_tick_prescaler.sv | 33 +++
 rtl/shot_clock_timer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/shot_clock_pkg.sv
// Shared types and default constants for the shot-clock timer.
package shot_clock_pkg;

  // Main FSM state; encoding is fixed so downstream debug can decode it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Classic full and short (offensive rebound) shot-clock presets.
  localparam int DEFAULT_PRESET_FULL  = 24;
  localparam int DEFAULT_PRESET_SHORT = 14;

endpackage

// File: rtl/shot_clock_timer_tick_prescaler.sv
// Seconds prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // A clear cycle never ticks, so a load always restarts a full second.
  assign tick = enable && !clear && (cnt_q == LAST);

  // Fraction-of-second counter; holds when disabled so a stopped clock keeps its fraction.
  always_ff @(posedge clock_in or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/shot_clock_timer.sv
// Parametrised shot-clock countdown with run/idle/expired FSM and timed buzzer.
module shot_clock_timer
  import shot_clock_pkg::*;
#(
  parameter int WIDTH        = 5,
  parameter int PRESET_FULL  = DEFAULT_PRESET_FULL,
  parameter int PRESET_SHORT = DEFAULT_PRESET_SHORT,
  parameter int TICK_DIV     = 50_000_000,
  parameter int BUZZ_TICKS   = 3
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             load_full,
  input  logic             load_short,
  input  logic             load_custom,
  input  logic [WIDTH-1:0] custom_value,
  input  logic             start_stop,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             buzzer
);

  localparam int BW = $clog2(BUZZ_TICKS + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [BW-1:0]    buzz_q, buzz_d;
  logic             buzzer_q, buzzer_d;
  logic             btn_q;
  logic             btn_edge;
  logic             load_any;
  logic [WIDTH-1:0] load_value;
  logic             presc_en;
  logic             tick;

  assign btn_edge = start_stop & ~btn_q;
  assign load_any = load_full | load_short | load_custom;

  // Load value by priority: full beats short beats custom.
  assign load_value = load_full  ? WIDTH'(PRESET_FULL)  :
                      load_short ? WIDTH'(PRESET_SHORT) : custom_value;

  // Prescaler counts while running unpaused, and always while the buzzer is timed.
  assign presc_en = ((state_q == RUN) && !pause) || (state_q == EXPIRED);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock_in(clock_in),
    .reset   (reset),
    .enable  (presc_en),
    .clear   (load_any),
    .tick    (tick)
  );

  // State, count, buzz timer, buzzer and button-history registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      buzz_q   <= '0;
      buzzer_q <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      buzz_q   <= buzz_d;
      buzzer_q <= buzzer_d;
      btn_q    <= start_stop;
    end
  end

  // Next-state logic: loads override the FSM, then per-state tick/button handling.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    state_d  = state_q;
    count_d  = count_q;
    buzz_d   = buzz_q;
    buzzer_d = buzzer_q;

    if (load_any) begin
      count_d  = load_value;
      buzzer_d = 1'b0;
      if (state_q == EXPIRED) state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_edge && (count_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (count_q == '0) begin
            // Only reachable by loading a custom zero while running.
            state_d = IDLE;
          end else if (tick && (count_q == WIDTH'(1))) begin
            // Expiry wins over a same-cycle button edge.
            count_d  = '0;
            state_d  = EXPIRED;
            buzzer_d = 1'b1;
            buzz_d   = BW'(BUZZ_TICKS);
          end else begin
            if (tick)     count_d = count_q - WIDTH'(1);
            if (btn_edge) state_d = IDLE;
          end
        end
        EXPIRED: begin
          if (tick) begin
            if (buzz_q <= BW'(1)) begin
              buzz_d   = '0;
              buzzer_d = 1'b0;
              state_d  = IDLE;
            end else begin
              buzz_d = buzz_q - BW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign buzzer  = buzzer_q;

endmodule
